// File: rtl/mem_if_pkg.sv
// ============================================================================
// Module   : mem_if_pkg
// Purpose  : Shared widths and controller state encoding for the RAM initiator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_if_pkg;

  localparam int c_ADDR_W = 9;
  localparam int c_DATA_W = 32;
  // Holds RD_LATENCY-1 for the supported latency range 1..4
  localparam int c_CNT_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage : mem_if_pkg

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MAR/MDR initiator for a single-port synchronous RAM, one request
//            in flight, valid/ready on both the request and response sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl
  import mem_if_pkg::*;
#(
  parameter int ADDR_W     = c_ADDR_W,
  parameter int DATA_W     = c_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_was_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [c_CNT_W-1:0] c_WAIT_INIT = c_CNT_W'(RD_LATENCY - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_mar;
  logic [DATA_W-1:0]   r_mdr;
  logic                r_is_write;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_mem_read;
  logic                r_mem_write;
  logic                r_rsp_valid;
  logic                r_rsp_was_write;

  // Strobes are pre-computed one state early so each is a clean register output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_mar           <= '0;
      r_mdr           <= '0;
      r_is_write      <= 1'b0;
      r_cnt           <= '0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_rsp_valid     <= 1'b0;
      r_rsp_was_write <= 1'b0;
    end else begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_mar       <= req_addr;
            r_is_write  <= req_write;
            r_mem_read  <= ~req_write;
            r_mem_write <= req_write;
            if (req_write) begin
              r_mdr <= req_wdata;
            end
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_is_write) begin
            r_rsp_valid     <= 1'b1;
            r_rsp_was_write <= 1'b1;
            r_state         <= S_RESP;
          end else begin
            r_cnt   <= c_WAIT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            // The only edge at which the RAM output is trusted
            r_mdr           <= mem_rdata;
            r_rsp_valid     <= 1'b1;
            r_rsp_was_write <= 1'b0;
            r_state         <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid     <= 1'b0;
            r_rsp_was_write <= 1'b0;
            r_state         <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid     <= 1'b0;
          r_rsp_was_write <= 1'b0;
          r_state         <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_mdr;
  assign rsp_was_write = r_rsp_was_write;
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_addr      = r_mar;
  assign mem_wdata     = r_mdr;

endmodule : mem_access_ctrl

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed bench for mem_access_ctrl at read latency 1 and 3,
//            each instance driving its own behavioural RAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

  localparam logic [31:0] c_JUNK = 32'hBAD0_BAD0;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_was_write;
  logic [31:0] rsp_rdata;
  logic        mem_read, mem_write, busy;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        req_valid3, req_ready3, req_write3;
  logic [8:0]  req_addr3;
  logic [31:0] req_wdata3;
  logic        rsp_valid3, rsp_ready3, rsp_was_write3;
  logic [31:0] rsp_rdata3;
  logic        mem_read3, mem_write3, busy3;
  logic [8:0]  mem_addr3;
  logic [31:0] mem_wdata3, mem_rdata3;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_pulses = 0;

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_was_write(rsp_was_write),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_write(req_write3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3),
    .rsp_was_write(rsp_was_write3),
    .mem_read(mem_read3), .mem_write(mem_write3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: the read pipeline carries real data only behind a mem_read
  // cycle, so a capture at the wrong edge picks up c_JUNK.
  logic [31:0] ram  [0:511];
  logic [31:0] ram3 [0:511];
  logic [31:0] pipe1;
  logic [31:0] p3_0, p3_1, p3_2;

  always @(posedge clk) begin
    if (!rst_n) begin
      ram[117] <= 32'h0000_0025;
      ram[106] <= 32'h0000_0029;
      pipe1    <= c_JUNK;
    end else begin
      if (mem_write) ram[mem_addr] <= mem_wdata;
      pipe1 <= mem_read ? ram[mem_addr] : c_JUNK;
    end
  end
  assign mem_rdata = pipe1;

  always @(posedge clk) begin
    if (!rst_n) begin
      ram3[5] <= 32'h0000_0055;
      p3_0 <= c_JUNK;
      p3_1 <= c_JUNK;
      p3_2 <= c_JUNK;
    end else begin
      if (mem_write3) ram3[mem_addr3] <= mem_wdata3;
      p3_0 <= mem_read3 ? ram3[mem_addr3] : c_JUNK;
      p3_1 <= p3_0;
      p3_2 <= p3_1;
    end
  end
  assign mem_rdata3 = p3_2;

  always @(posedge clk) begin
    if (mem_write) wr_pulses <= wr_pulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for the accept edge, then withdraw it
  task automatic issue(input logic wr, input logic [8:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin : stim
    int start_pulses;
    int cyc;
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    req_valid3 = 1'b0; req_write3 = 1'b0; req_addr3 = '0; req_wdata3 = '0; rsp_ready3 = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_mem_read",  32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_was_write", 32'(rsp_was_write), 32'd0);
    chk("rst_mar",       32'(mem_addr), 32'd0);
    chk("rst_mdr",       rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // Load 117, rsp_ready already high
    rsp_ready = 1'b1;
    issue(1'b0, 9'd117, 32'h0);
    chk("ld1_mem_read",  32'(mem_read), 32'd1);
    chk("ld1_addr",      32'(mem_addr), 32'd117);
    chk("ld1_req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("ld1_read_pulse", 32'(mem_read), 32'd0);
    chk("ld1_no_early_rsp", 32'(rsp_valid), 32'd0);
    tick();
    chk("ld1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ld1_rdata",     rsp_rdata, 32'h0000_0025);
    chk("ld1_was_write", 32'(rsp_was_write), 32'd0);
    tick();
    chk("ld1_idle", 32'(busy), 32'd0);
    chk("ld1_rsp_drop", 32'(rsp_valid), 32'd0);

    // Store 0x67 to 0x090, then read it back
    start_pulses = wr_pulses;
    issue(1'b1, 9'h090, 32'h0000_0067);
    chk("st_mem_write", 32'(mem_write), 32'd1);
    chk("st_addr",      32'(mem_addr), 32'h090);
    chk("st_wdata",     mem_wdata, 32'h0000_0067);
    chk("st_no_read",   32'(mem_read), 32'd0);
    tick();
    chk("st_write_pulse", 32'(mem_write), 32'd0);
    chk("st_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("st_was_write", 32'(rsp_was_write), 32'd1);
    chk("st_echo",      rsp_rdata, 32'h0000_0067);
    tick();
    chk("st_idle", 32'(busy), 32'd0);
    chk("st_pulse_count", 32'(wr_pulses - start_pulses), 32'd1);
    issue(1'b0, 9'h090, 32'h0);
    tick(); tick();
    chk("raw_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("raw_rdata", rsp_rdata, 32'h0000_0067);
    tick();

    // Backpressure on load 106
    rsp_ready = 1'b0;
    issue(1'b0, 9'd106, 32'h0);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata",     rsp_rdata, 32'h0000_0029);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_idle", 32'(req_ready), 32'd1);
    chk("bp_rsp_drop", 32'(rsp_valid), 32'd0);

    // Second request held while busy is ignored until after the handshake
    rsp_ready = 1'b0;
    issue(1'b0, 9'd117, 32'h0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h1FF; req_wdata = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    chk("ign_mar", 32'(mem_addr), 32'd117);
    chk("ign_mdr", rsp_rdata, 32'h0000_0025);
    chk("ign_no_write", 32'(mem_write), 32'd0);
    chk("ign_rsp_valid", 32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick();
    chk("ign_handshake_idle", 32'(busy), 32'd0);
    chk("ign_not_yet", 32'(mem_write), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("ign_accept_write", 32'(mem_write), 32'd1);
    chk("ign_accept_addr",  32'(mem_addr), 32'h1FF);
    chk("ign_accept_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("ign_rsp", 32'(rsp_was_write), 32'd1);
    tick();

    // Reset during store ISSUE
    issue(1'b1, 9'h020, 32'h0000_0011);
    chk("mrst_pre_write", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_async_drop", 32'(mem_write), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mrst_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end

    // Latency-3 instance: load RAM[5]
    rsp_ready3 = 1'b1;
    req_valid3 = 1'b1; req_write3 = 1'b0; req_addr3 = 9'd5;
    tick();
    req_valid3 = 1'b0;
    chk("l3_mem_read", 32'(mem_read3), 32'd1);
    cyc = 1;
    for (int i = 0; i < 10 && !rsp_valid3; i++) begin
      tick();
      cyc++;
    end
    chk("l3_latency", 32'(cyc), 32'd5);
    chk("l3_rdata", rsp_rdata3, 32'h0000_0055);
    tick();
    chk("l3_idle", 32'(busy3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_access_ctrl

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the single-port synchronous RAM. It holds the MAR/MDR pair and accepts one load/store request at a time from the control unit over a valid/ready handshake. It drives the RAM's Read, Write, Addr_in and Data_in pins and captures Data_out after the RAM's registered read latency. It returns read data or a write acknowledge over a second valid/ready handshake.

Parameters:
ADDR_W, 9, RAM word-address width (512 words)
DATA_W, 32, data word width
RD_LATENCY, 1, clock edges from the RAM sampling the address to Data_out being valid (range 1..4)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  control unit presents a request
req_ready  out  1  controller can accept a request (IDLE only)
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address, loaded into MAR on accept
req_wdata  in  DATA_W  store data, loaded into MDR on accept
rsp_valid  out  1  response available
rsp_ready  in  1  control unit takes the response
rsp_rdata  out  DATA_W  MDR contents (load data; store data echoed on a store)
rsp_was_write  out  1  response belongs to a store
mem_read  out  1  to RAM Read
mem_write  out  1  to RAM Write
mem_addr  out  ADDR_W  to RAM Addr_in (always the MAR value)
mem_wdata  out  DATA_W  to RAM Data_in (always the MDR value)
mem_rdata  in  DATA_W  from RAM Data_out
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; MAR=0, MDR=0, wait counter=0; mem_read=0, mem_write=0, rsp_valid=0, rsp_was_write=0, busy=0; req_ready=1 once rst_n=1.
- All mem_* and rsp_* outputs are registered or decoded from registered state only. There is no combinational path from a req_* input to a mem_* output.
- Accept: req_valid & req_ready at edge E0. MAR<=req_addr. On a store, MDR<=req_wdata. Latch the write flag. Go to ISSUE.
- ISSUE (1 cycle): load -> mem_read=1; store -> mem_write=1. mem_write is exactly a one-cycle pulse per store. The RAM samples at edge E1.
  - Store: ISSUE -> RESP.
  - Load: ISSUE -> WAIT with counter=RD_LATENCY-1.
- WAIT: mem_read=0. While counter!=0, decrement. When counter==0, MDR<=mem_rdata at that edge and go to RESP. With RD_LATENCY=1, WAIT lasts 1 cycle.
- RESP: rsp_valid=1, rsp_rdata=MDR, rsp_was_write=flag. Hold stable until rsp_ready=1. At the handshake edge go to IDLE.
- Latency: a load's rsp_valid rises 2+RD_LATENCY cycles after accept (3 at default). A store's rsp_valid rises 2 cycles after accept.
- Throughput: a new request is accepted the cycle after the response handshake. There is no overlap.
- rsp_ready held high before rsp_valid has no effect. req_valid is ignored outside IDLE; the request must stay asserted until accepted.
- Reset mid-operation: the in-flight request is dropped with no response. mem_write deasserts asynchronously. A partially issued store may or may not have been written; the caller must re-issue it.
- The RAM updates Data_out on every edge, including on writes. The controller ignores mem_rdata except at the WAIT capture edge.
- A store followed by a load to the same address must return the new data. This holds by construction because the store completes before the load is accepted.
- Illegal states decode to IDLE.

Decomposition:
- Shared package mem_if_pkg: ADDR_W/DATA_W defaults and the state enum (IDLE, ISSUE, WAIT, RESP).
- Single module. No sub-module is needed; MAR/MDR are plain registers inside it.

Test Plan:
- Preload RAM[117]=0x00000025. Load addr 117 with rsp_ready=1 -> mem_read pulses 1 cycle, rsp_valid rises 3 cycles after accept, rsp_rdata=0x00000025, rsp_was_write=0.
- Store 0x00000067 to addr 0x090, then load 0x090 -> exactly one mem_write pulse with mem_addr=0x090 and mem_wdata=0x67; the load returns 0x00000067.
- Backpressure: load RAM[106]=0x00000029 with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata hold 0x29 stable; req_ready=0 throughout; IDLE is entered the cycle after rsp_ready=1.
- req_valid asserted while busy with different addr/data -> ignored; MAR/MDR unchanged; the second request is accepted only after the first response handshake.
- Assert rst_n=0 during the store ISSUE cycle -> mem_write drops immediately, rsp_valid never asserts, req_ready=1 after release.
- RD_LATENCY=3 build: load RAM[5] -> rsp_valid arrives 5 cycles after accept; data is captured from mem_rdata exactly 3 edges after the mem_read cycle.
